// File: rtl/pico_park_pkg.sv
// Shared types and defaults for the level sequencer: state codes, level index, fall line.
package pico_park_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_INIT  = 3'b001,
    ST_PLAY  = 3'b010,
    ST_KEY   = 3'b011,
    ST_CLEAR = 3'b100,
    ST_DEATH = 3'b101,
    ST_WIN   = 3'b110,
    ST_BAD   = 3'b111
  } state_t;

  typedef logic [1:0] level_t;

  localparam logic [11:0] FALL_Y_DEF = 12'd470;
  localparam int          TIMER_W    = 8;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: pulses for the cycle in which the input goes 0 -> 1.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  always_ff @(posedge Clk) begin
    if (Reset) r_sig_d <= 1'b0;
    else       r_sig_d <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/level_sequencer.sv
// Game/level phase FSM: sequences title, init, play, key, clear, death and win,
// timing phases in frame ticks and publishing the state code to the datapath blocks.
module level_sequencer
  import pico_park_pkg::*;
#(
  parameter int          INIT_FRAMES  = 2,
  parameter int          CLEAR_FRAMES = 120,
  parameter int          DEATH_FRAMES = 60,
  parameter int          NUM_LEVELS   = 3,
  parameter logic [11:0] FALL_Y       = FALL_Y_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start_key,
  input  logic [11:0] ball_y_blue,
  input  logic [11:0] ball_y_red,
  input  logic        key_touch,
  input  logic        door_blue,
  input  logic        door_red,
  output logic [2:0]  statenumber,
  output logic [1:0]  level,
  output logic        key_taken,
  output logic        respawn,
  output logic        game_won
);

  localparam logic [TIMER_W-1:0] INIT_LAST  = TIMER_W'(INIT_FRAMES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_FRAMES - 1);
  localparam logic [TIMER_W-1:0] DEATH_LAST = TIMER_W'(DEATH_FRAMES - 1);
  localparam level_t             LEVEL_LAST = level_t'(NUM_LEVELS - 1);

  state_t               r_state;
  level_t               r_level;
  logic                 r_key_taken;
  logic                 r_respawn;
  logic [TIMER_W-1:0]   r_timer;

  state_t               w_next;
  level_t               w_level_next;
  logic                 w_key_next;
  logic                 w_respawn_next;
  logic                 w_tick;
  logic                 w_start;
  logic                 w_fell;

  rise_detect u_tick_det (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_sig  (frame_clk),
    .o_rise (w_tick)
  );

  rise_detect u_start_det (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_sig  (start_key),
    .o_rise (w_start)
  );

  assign w_fell = (ball_y_blue >= FALL_Y) | (ball_y_red >= FALL_Y);

  always_comb begin
    w_next       = r_state;
    w_level_next = r_level;
    w_key_next   = r_key_taken;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next       = ST_INIT;
          w_level_next = '0;
        end
      end
      ST_INIT: begin
        w_key_next = 1'b0;
        if (w_tick && r_timer == INIT_LAST) w_next = ST_PLAY;
      end
      // A fall always beats progress in the two live phases.
      ST_PLAY: begin
        if (w_fell) w_next = ST_DEATH;
        else if (key_touch) begin
          w_next     = ST_KEY;
          w_key_next = 1'b1;
        end
      end
      ST_KEY: begin
        if (w_fell)                     w_next = ST_DEATH;
        else if (door_blue && door_red) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (w_tick && r_timer == CLEAR_LAST) begin
          if (r_level == LEVEL_LAST) w_next = ST_WIN;
          else begin
            w_next       = ST_INIT;
            w_level_next = r_level + level_t'(1);
          end
        end
      end
      ST_DEATH: begin
        if (w_tick && r_timer == DEATH_LAST) w_next = ST_INIT;
      end
      ST_WIN: begin
        if (w_start) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_respawn_next = (w_next == ST_DEATH) && (r_state != ST_DEATH);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_level     <= '0;
      r_key_taken <= 1'b0;
      r_respawn   <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_next;
      r_level     <= w_level_next;
      r_key_taken <= w_key_next;
      r_respawn   <= w_respawn_next;
      // Phase timer restarts on every state change and sticks at all-ones.
      if (w_next != r_state)             r_timer <= '0;
      else if (w_tick && ~&r_timer)      r_timer <= r_timer + 1'b1;
    end
  end

  assign statenumber = r_state;
  assign level       = r_level;
  assign key_taken   = r_key_taken;
  assign respawn     = r_respawn;
  assign game_won    = (r_state == ST_WIN);

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: walks the phase sequence with hand-computed expectations.
module tb_level_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        start_key = 1'b0;
  logic [11:0] ball_y_blue = 12'd0;
  logic [11:0] ball_y_red = 12'd0;
  logic        key_touch = 1'b0;
  logic        door_blue = 1'b0;
  logic        door_red = 1'b0;
  logic [2:0]  statenumber;
  logic [1:0]  level;
  logic        key_taken;
  logic        respawn;
  logic        game_won;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] IDLE = 3'b000, INIT = 3'b001, PLAY = 3'b010, KEY = 3'b011,
                         CLEAR = 3'b100, DEATH = 3'b101, WIN = 3'b110;

  level_sequencer #(
    .INIT_FRAMES  (2),
    .CLEAR_FRAMES (120),
    .DEATH_FRAMES (60),
    .NUM_LEVELS   (3),
    .FALL_Y       (12'd470)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .start_key   (start_key),
    .ball_y_blue (ball_y_blue),
    .ball_y_red  (ball_y_red),
    .key_touch   (key_touch),
    .door_blue   (door_blue),
    .door_red    (door_red),
    .statenumber (statenumber),
    .level       (level),
    .key_taken   (key_taken),
    .respawn     (respawn),
    .game_won    (game_won)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From INIT: two ticks to PLAY, grab key, both players at the door.
  task automatic to_clear();
    ticks(2);
    key_touch = 1'b1;
    step();
    key_touch = 1'b0;
    door_blue = 1'b1;
    door_red  = 1'b1;
    step();
    door_blue = 1'b0;
    door_red  = 1'b0;
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    step();
    step();
    check("rst_state", 12'(statenumber), 12'(IDLE));
    check("rst_level", 12'(level), 12'd0);
    check("rst_key", 12'(key_taken), 12'd0);
    check("rst_respawn", 12'(respawn), 12'd0);
    check("rst_won", 12'(game_won), 12'd0);
    Reset = 1'b0;

    // Start held 10 cycles: single INIT entry, then two ticks to PLAY
    start_key = 1'b1;
    step();
    check("start_init", 12'(statenumber), 12'(INIT));
    for (int i = 0; i < 9; i++) step();
    check("start_held_init", 12'(statenumber), 12'(INIT));
    start_key = 1'b0;
    tick();
    check("init_tick1", 12'(statenumber), 12'(INIT));
    tick();
    check("init_tick2_play", 12'(statenumber), 12'(PLAY));
    check("play_key0", 12'(key_taken), 12'd0);

    // Key, door with only one player, then both
    key_touch = 1'b1;
    step();
    key_touch = 1'b0;
    check("play_key_state", 12'(statenumber), 12'(KEY));
    check("play_key_taken", 12'(key_taken), 12'd1);
    door_blue = 1'b1;
    step();
    check("door_one_stays", 12'(statenumber), 12'(KEY));
    door_red = 1'b1;
    step();
    door_blue = 1'b0;
    door_red  = 1'b0;
    check("door_both_clear", 12'(statenumber), 12'(CLEAR));

    // CLEAR at level 0: 119 ticks stays, 120th advances
    ticks(119);
    check("clear_119", 12'(statenumber), 12'(CLEAR));
    check("clear_119_lvl", 12'(level), 12'd0);
    tick();
    check("clear_120_init", 12'(statenumber), 12'(INIT));
    check("clear_120_lvl", 12'(level), 12'd1);
    check("init_key_clr", 12'(key_taken), 12'd0);

    // Level 1: fall boundary, then fall beats door in KEY
    ticks(2);
    check("lvl1_play", 12'(statenumber), 12'(PLAY));
    ball_y_blue = 12'd469;
    step();
    check("y469_no_fall", 12'(statenumber), 12'(PLAY));
    ball_y_blue = 12'd0;
    key_touch = 1'b1;
    step();
    key_touch = 1'b0;
    check("lvl1_key", 12'(statenumber), 12'(KEY));
    ball_y_red = 12'd470;
    door_blue  = 1'b1;
    door_red   = 1'b1;
    step();
    ball_y_red = 12'd0;
    door_blue  = 1'b0;
    door_red   = 1'b0;
    check("fall_death", 12'(statenumber), 12'(DEATH));
    check("respawn_first", 12'(respawn), 12'd1);
    step();
    check("respawn_second", 12'(respawn), 12'd0);
    check("death_hold", 12'(statenumber), 12'(DEATH));
    ticks(59);
    check("death_59", 12'(statenumber), 12'(DEATH));
    tick();
    check("death_60_init", 12'(statenumber), 12'(INIT));
    check("death_lvl_kept", 12'(level), 12'd1);
    check("death_key_clr", 12'(key_taken), 12'd0);

    // Reset in the middle of CLEAR at level 1
    to_clear();
    ticks(50);
    check("mid_clear", 12'(statenumber), 12'(CLEAR));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_state", 12'(statenumber), 12'(IDLE));
    check("midrst_level", 12'(level), 12'd0);
    check("midrst_key", 12'(key_taken), 12'd0);
    check("midrst_won", 12'(game_won), 12'd0);

    // Full run to the last level and WIN
    start_key = 1'b1;
    step();
    start_key = 1'b0;
    to_clear();
    ticks(120);
    to_clear();
    ticks(120);
    check("lvl2_init", 12'(level), 12'd2);
    to_clear();
    check("lvl2_clear", 12'(statenumber), 12'(CLEAR));
    ticks(119);
    check("lvl2_clear_119", 12'(statenumber), 12'(CLEAR));
    tick();
    check("win_state", 12'(statenumber), 12'(WIN));
    check("win_flag", 12'(game_won), 12'd1);
    check("win_level", 12'(level), 12'd2);
    ball_y_blue = 12'd500;
    step();
    ball_y_blue = 12'd0;
    check("win_ignores_fall", 12'(statenumber), 12'(WIN));
    start_key = 1'b1;
    step();
    check("win_start_idle", 12'(statenumber), 12'(IDLE));
    check("idle_won0", 12'(game_won), 12'd0);
    step();
    check("held_start_idle", 12'(statenumber), 12'(IDLE));
    start_key = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
